// File: rtl/apb_1553_pkg.sv
// Shared constants for the APB front end of the 1553B core: register offsets,
// CTRL/STATUS bit positions, FSM state encodings and the sticky error bundle.
package apb_1553_pkg;

    // Word offsets, decoded from paddr[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;

    localparam int CTRL_PARITY = 0;
    localparam int CTRL_RX_IE  = 1;
    localparam int CTRL_TX_IE  = 2;
    localparam int CTRL_ERR_IE = 3;

    localparam int STAT_RX_UNEMPTY  = 0;
    localparam int STAT_TX_UNFULL   = 1;
    localparam int STAT_RX_UNDERRUN = 2;
    localparam int STAT_TX_TIMEOUT  = 3;
    localparam int STAT_BAD_ADDR    = 4;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE    = 2'd0;
    localparam apb_state_t ST_ACCESS  = 2'd1;
    localparam apb_state_t ST_TX_WAIT = 2'd2;

    typedef struct packed {
        logic bad_addr;
        logic tx_timeout;
        logic rx_underrun;
    } err_flags_t;

    function automatic logic is_mapped(input logic [2:0] sel);
        return sel <= REG_COUNT;
    endfunction

endpackage

// File: rtl/apb_1553_bus_if.sv
// APB3 signal bundle between the SoC fabric (master) and the 1553B front end (slave).
interface apb_1553_bus_if #(
    parameter int ADDR_W = 12
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_1553_regs.sv
// Register file for the 1553B APB front end: CTRL, sticky STATUS errors,
// word counters and the registered level interrupt.
module apb_1553_regs
    import apb_1553_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  reg_sel,
    input  logic [4:0]  wdata,
    input  logic        tx_push,
    input  logic        rx_pop,
    input  err_flags_t  err_ev,
    input  logic        r_fifo_unempty,
    input  logic        w_fifo_unfull,
    output logic        parity_set,
    output logic        irq,
    output logic [31:0] reg_rdata
);

    logic       rx_ie;
    logic       tx_ie;
    logic       err_ie;
    err_flags_t sticky;
    err_flags_t w1c_mask;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_count;

    assign wr_ctrl   = wr_en && (reg_sel == REG_CTRL);
    assign wr_status = wr_en && (reg_sel == REG_STATUS);
    assign wr_count  = wr_en && (reg_sel == REG_COUNT);

    always_comb begin
        w1c_mask             = '0;
        w1c_mask.rx_underrun = wr_status & wdata[STAT_RX_UNDERRUN];
        w1c_mask.tx_timeout  = wr_status & wdata[STAT_TX_TIMEOUT];
        w1c_mask.bad_addr    = wr_status & wdata[STAT_BAD_ADDR];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_set <= 1'b0;
            rx_ie      <= 1'b0;
            tx_ie      <= 1'b0;
            err_ie     <= 1'b0;
        end else if (wr_ctrl) begin
            parity_set <= wdata[CTRL_PARITY];
            rx_ie      <= wdata[CTRL_RX_IE];
            tx_ie      <= wdata[CTRL_TX_IE];
            err_ie     <= wdata[CTRL_ERR_IE];
        end
    end

    // A new event on a bit outranks a W1C of that same bit in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~w1c_mask) | err_ev;
        end
    end

    // Clear outranks a coincident increment
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count <= '0;
            rx_count <= '0;
        end else if (wr_count) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_count <= tx_count + 16'd1;
            end
            if (rx_pop) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (rx_ie & r_fifo_unempty)
                 | (tx_ie & w_fifo_unfull)
                 | (err_ie & (sticky.rx_underrun | sticky.tx_timeout | sticky.bad_addr));
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                reg_rdata[CTRL_PARITY] = parity_set;
                reg_rdata[CTRL_RX_IE]  = rx_ie;
                reg_rdata[CTRL_TX_IE]  = tx_ie;
                reg_rdata[CTRL_ERR_IE] = err_ie;
            end
            REG_STATUS: begin
                reg_rdata[STAT_RX_UNEMPTY]  = r_fifo_unempty;
                reg_rdata[STAT_TX_UNFULL]   = w_fifo_unfull;
                reg_rdata[STAT_RX_UNDERRUN] = sticky.rx_underrun;
                reg_rdata[STAT_TX_TIMEOUT]  = sticky.tx_timeout;
                reg_rdata[STAT_BAD_ADDR]    = sticky.bad_addr;
            end
            REG_COUNT: begin
                reg_rdata = {rx_count, tx_count};
            end
            default: begin
                reg_rdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/apb_1553_if.sv
// APB3 slave front end for the 1553B core: APB FSM, TX-full stall counter and
// the decoder-pop / encoder-push strobes; registers live in apb_1553_regs.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no transfer in progress, waiting for an APB setup phase
//   ST_ACCESS  | access phase; completes this cycle unless TXDATA write hits a full FIFO
//   ST_TX_WAIT | TXDATA write stalled on a full encoder FIFO, bounded by TX_TIMEOUT
module apb_1553_if
    import apb_1553_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int TX_TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    apb_1553_bus_if.slave apb,
    output logic          irq,
    output logic          parity_set,
    output logic          r_fifo_rd,
    input  logic          r_fifo_unempty,
    input  logic [23:0]   r_fifo_data,
    output logic          w_fifo_wd,
    input  logic          w_fifo_unfull,
    output logic [23:0]   w_fifo_data
);

    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

    apb_state_t       state;
    apb_state_t       state_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [2:0]       reg_sel;
    logic             in_access;
    logic             in_wait;
    logic             sel_tx_wr;
    logic             sel_rx_rd;
    logic             tx_stall;
    logic             timeout_hit;
    logic             done;
    logic             reg_wr_en;
    err_flags_t       err_ev;
    logic [31:0]      reg_rdata;
    logic [31:0]      rdata_mux;
    logic             unused_bits;

    assign unused_bits = ^{apb.paddr[ADDR_W-1:5], apb.paddr[1:0], apb.pwdata[31:24]};

    assign reg_sel   = apb.paddr[4:2];
    assign in_access = (state == ST_ACCESS) && apb.psel && apb.penable && !rst;
    assign in_wait   = (state == ST_TX_WAIT) && !rst;
    assign sel_tx_wr = apb.pwrite && (reg_sel == REG_TXDATA);
    assign sel_rx_rd = !apb.pwrite && (reg_sel == REG_RXDATA);

    assign tx_stall    = in_access && sel_tx_wr && !w_fifo_unfull;
    // A late unfull wins over a timeout that lands in the same cycle
    assign timeout_hit = in_wait && !w_fifo_unfull && (stall_cnt == CNT_W'(TX_TIMEOUT));
    assign done        = (in_access && !tx_stall) || (in_wait && (w_fifo_unfull || timeout_hit));

    assign w_fifo_wd   = (in_access && sel_tx_wr && w_fifo_unfull) || (in_wait && w_fifo_unfull);
    assign r_fifo_rd   = in_access && sel_rx_rd && r_fifo_unempty;
    assign w_fifo_data = apb.pwdata[23:0];

    always_comb begin
        err_ev             = '0;
        err_ev.rx_underrun = in_access && sel_rx_rd && !r_fifo_unempty;
        err_ev.bad_addr    = in_access && !is_mapped(reg_sel);
        err_ev.tx_timeout  = timeout_hit;
    end

    assign reg_wr_en   = in_access && apb.pwrite && is_mapped(reg_sel);
    assign apb.pready  = done;
    assign apb.pslverr = err_ev.rx_underrun | err_ev.bad_addr | err_ev.tx_timeout;

    always_comb begin
        rdata_mux = '0;
        if (in_access && !apb.pwrite) begin
            case (reg_sel)
                REG_CTRL, REG_STATUS, REG_COUNT: rdata_mux = reg_rdata;
                REG_RXDATA: rdata_mux = r_fifo_unempty ? {8'h00, r_fifo_data} : 32'h0;
                default:    rdata_mux = '0;
            endcase
        end
    end

    assign apb.prdata = rdata_mux;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (tx_stall) begin
                    state_nxt = ST_TX_WAIT;
                end else if (in_access || !apb.psel) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TX_WAIT: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (tx_stall) begin
            stall_cnt <= '0;
        end else if (in_wait && !done) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    apb_1553_regs u_regs (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (reg_wr_en),
        .reg_sel        (reg_sel),
        .wdata          (apb.pwdata[4:0]),
        .tx_push        (w_fifo_wd),
        .rx_pop         (r_fifo_rd),
        .err_ev         (err_ev),
        .r_fifo_unempty (r_fifo_unempty),
        .w_fifo_unfull  (w_fifo_unfull),
        .parity_set     (parity_set),
        .irq            (irq),
        .reg_rdata      (reg_rdata)
    );

endmodule

// File: tb/tb_apb_1553_if.sv
// Directed self-checking bench for apb_1553_if with TX_TIMEOUT = 4.
module tb_apb_1553_if;
    import apb_1553_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        irq;
    logic        parity_set;
    logic        r_fifo_rd;
    logic        r_fifo_unempty;
    logic [23:0] r_fifo_data;
    logic        w_fifo_wd;
    logic        w_fifo_unfull;
    logic [23:0] w_fifo_data;

    apb_1553_bus_if #(.ADDR_W(12)) bus ();

    apb_1553_if #(.ADDR_W(12), .TX_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .apb            (bus),
        .irq            (irq),
        .parity_set     (parity_set),
        .r_fifo_rd      (r_fifo_rd),
        .r_fifo_unempty (r_fifo_unempty),
        .r_fifo_data    (r_fifo_data),
        .w_fifo_wd      (w_fifo_wd),
        .w_fifo_unfull  (w_fifo_unfull),
        .w_fifo_data    (w_fifo_data)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          wd_cnt   = 0;
    int          rd_cnt   = 0;
    logic [23:0] wd_last  = '0;
    logic [23:0] rxq[$];
    logic        pop_pending;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe monitor
    initial begin
        forever begin
            @(negedge clk);
            if (w_fifo_wd === 1'b1) begin
                wd_cnt++;
                wd_last = w_fifo_data;
            end
            if (r_fifo_rd === 1'b1) rd_cnt++;
        end
    end

    // First-word-fall-through decoder FIFO model
    initial begin
        r_fifo_unempty = 1'b0;
        r_fifo_data    = '0;
        forever begin
            @(negedge clk);
            pop_pending = r_fifo_rd;
            @(posedge clk);
            #2;
            if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
            r_fifo_unempty = (rxq.size() > 0);
            r_fifo_data    = (rxq.size() > 0) ? rxq[0] : 24'h0;
        end
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        waits = 0;
        while (bus.pready !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check_val("pready_bound", {31'b0, bus.pready}, 32'd1);
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_xfer(1'b0, addr, 32'h0, d, e, w);
        check_val({tag, "_data"}, d, exp_data);
        check_val({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic wr_do(input logic [11:0] addr, input logic [31:0] data,
                         output logic err, output int waits);
        logic [31:0] d;
        apb_xfer(1'b1, addr, data, d, err, waits);
    endtask

    initial begin
        logic e;
        int   w;
        int   wd0;
        int   rd0;
        int   k;

        rst           = 1'b1;
        w_fifo_unfull = 1'b1;
        bus.psel      = 1'b0;
        bus.penable   = 1'b0;
        bus.pwrite    = 1'b0;
        bus.paddr     = '0;
        bus.pwdata    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_val("rst_pready", {31'b0, bus.pready}, 32'd0);
        check_val("rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        check_val("rst_prdata", bus.prdata, 32'd0);
        check_val("rst_irq", {31'b0, irq}, 32'd0);
        check_val("rst_strobes", {30'b0, w_fifo_wd, r_fifo_rd}, 32'd0);
        check_val("rst_parity", {31'b0, parity_set}, 32'd0);

        rd_chk("ctrl0", 12'h000, 32'h0, 1'b0);
        rd_chk("status0", 12'h004, 32'h2, 1'b0);
        rd_chk("count0", 12'h010, 32'h0, 1'b0);
        rd_chk("txdata_rd", 12'h008, 32'h0, 1'b0);
        rd_chk("badaddr", 12'h014, 32'h0, 1'b1);
        rd_chk("status_bad", 12'h004, 32'h12, 1'b0);
        wr_do(12'h004, 32'h10, e, w);
        rd_chk("status_badclr", 12'h004, 32'h2, 1'b0);

        // Zero-wait push
        wd0 = wd_cnt;
        wr_do(12'h008, 32'h00AB1234, e, w);
        check_val("tx_waits", w, 0);
        check_val("tx_err", {31'b0, e}, 32'd0);
        check_val("tx_pushes", wd_cnt - wd0, 1);
        check_val("tx_data", {8'h0, wd_last}, 32'h00AB1234);
        rd_chk("count_tx1", 12'h010, 32'h1, 1'b0);

        // Timeout: ACCESS cycle plus TO stalled TX_WAIT cycles, then error completion
        w_fifo_unfull = 1'b0;
        wd0 = wd_cnt;
        wr_do(12'h008, 32'h00000011, e, w);
        check_val("to_waits", w, TO + 1);
        check_val("to_err", {31'b0, e}, 32'd1);
        check_val("to_pushes", wd_cnt - wd0, 0);
        rd_chk("status_to", 12'h004, 32'h08, 1'b0);

        // Space appears after two stalled cycles
        wd0 = wd_cnt;
        fork
            wr_do(12'h008, 32'h00CD0077, e, w);
            begin
                repeat (4) @(posedge clk);
                #1 w_fifo_unfull = 1'b1;
            end
        join
        check_val("late_waits", w, 2);
        check_val("late_err", {31'b0, e}, 32'd0);
        check_val("late_pushes", wd_cnt - wd0, 1);
        check_val("late_data", {8'h0, wd_last}, 32'h00CD0077);
        wr_do(12'h004, 32'h8, e, w);
        rd_chk("status_toclr", 12'h004, 32'h2, 1'b0);
        rd_chk("count_tx2", 12'h010, 32'h2, 1'b0);

        // Receive path
        @(posedge clk); #1 rxq.push_back(24'h5A00FF);
        repeat (3) @(posedge clk);
        rd0 = rd_cnt;
        rd_chk("rx_word", 12'h00C, 32'h005A00FF, 1'b0);
        check_val("rx_pops", rd_cnt - rd0, 1);
        rd_chk("count_rx1", 12'h010, 32'h00010002, 1'b0);
        rd0 = rd_cnt;
        rd_chk("rx_empty", 12'h00C, 32'h0, 1'b1);
        check_val("rx_empty_pops", rd_cnt - rd0, 0);
        rd_chk("status_ur", 12'h004, 32'h6, 1'b0);
        wr_do(12'h004, 32'h4, e, w);
        rd_chk("status_urclr", 12'h004, 32'h2, 1'b0);
        wr_do(12'h010, 32'hFFFFFFFF, e, w);
        rd_chk("count_clr", 12'h010, 32'h0, 1'b0);

        // Interrupt follows rx_ie & r_fifo_unempty with one cycle of lag
        wr_do(12'h000, 32'h2, e, w);
        rd_chk("ctrl_rxie", 12'h000, 32'h2, 1'b0);
        @(negedge clk);
        check_val("irq_idle", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 rxq.push_back(24'h123456);
        k = 0;
        @(negedge clk);
        while (r_fifo_unempty !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("irq_lag_rise", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check_val("irq_rise", {31'b0, irq}, 32'd1);
        rd_chk("rx_word2", 12'h00C, 32'h00123456, 1'b0);
        k = 0;
        @(negedge clk);
        while (r_fifo_unempty !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("irq_lag_fall", {31'b0, irq}, 32'd1);
        @(negedge clk);
        check_val("irq_fall", {31'b0, irq}, 32'd0);
        wr_do(12'h000, 32'h0, e, w);
        rd_chk("count_rx_only", 12'h010, 32'h00010000, 1'b0);

        // Counter wrap; the preload is forced to keep the run short
        @(posedge clk); #1;
        force dut.u_regs.tx_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.u_regs.tx_count;
        wr_do(12'h008, 32'h1, e, w);
        rd_chk("count_ffff", 12'h010, 32'h0001FFFF, 1'b0);
        wr_do(12'h008, 32'h2, e, w);
        rd_chk("count_wrap", 12'h010, 32'h00010000, 1'b0);

        // Reset while stalled in TX_WAIT, with space appearing in the reset cycle
        w_fifo_unfull = 1'b0;
        wd0 = wd_cnt;
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 12'h008;
        bus.pwdata  = 32'h00BEEF00;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        check_val("wait_state", {30'b0, dut.state}, {30'b0, ST_TX_WAIT});
        rst           = 1'b1;
        w_fifo_unfull = 1'b1;
        @(negedge clk);
        check_val("rstw_pready", {31'b0, bus.pready}, 32'd0);
        check_val("rstw_pslverr", {31'b0, bus.pslverr}, 32'd0);
        check_val("rstw_wd", {31'b0, w_fifo_wd}, 32'd0);
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        check_val("rstw_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        check_val("rstw_irq", {31'b0, irq}, 32'd0);
        check_val("rstw_prdata", bus.prdata, 32'd0);
        check_val("rstw_pushes", wd_cnt - wd0, 0);
        rd_chk("rstw_count", 12'h010, 32'h0, 1'b0);
        wr_do(12'h008, 32'h00000055, e, w);
        check_val("post_rst_push", wd_cnt - wd0, 1);
        check_val("post_rst_err", {31'b0, e}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
